// File: rtl/seven_seg_pkg.sv
// Shared constants, slot indices and output payload for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned NUM_PHASES = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

  localparam logic [SLOT_W-1:0] SLOT_S0 = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_S1 = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_M0 = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_M1 = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_H0 = 3'd4;
  localparam logic [SLOT_W-1:0] SLOT_H1 = 3'd5;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DRIVE = 2'd1,
    DARK  = 2'd2
  } scan_state_t;

  // Everything that leaves the chip toward the display pins.
  typedef struct packed {
    logic [SEG_W-1:0]      seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
  } disp_out_t;

  localparam disp_out_t DISP_OFF = '{seg: SEG_BLANK, dp: 1'b1, an: 6'h3F};

  // Phase 0 is the anti-ghost gap; phases 1..bright light the digit.
  function automatic scan_state_t phase_state(input logic [PHASE_W-1:0] phase,
                                              input logic [2:0]         bright);
    scan_state_t st;
    if (phase == '0) begin
      st = BLANK;
    end else if (phase <= bright) begin
      st = DRIVE;
    end else begin
      st = DARK;
    end
    return st;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_tick.sv
// scan_tick_gen: slot timing, phase extraction and frame strobe for the digit scan.
module scan_tick_gen
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [SLOT_W-1:0] slot,
  output logic [PHASE_W-1:0] phase,
  output logic              slot_start_c,
  output logic              frame_end_c,
  output logic              frame_done
);

  localparam int unsigned TICK_W = $clog2(SCAN_DIV);
  localparam int unsigned PH_LEN = SCAN_DIV / NUM_PHASES;
  localparam int unsigned SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               frame_done_q, frame_done_d;
  logic               tick_last_c;
  logic               sub_last_c;

  assign tick_last_c  = (tick_q == TICK_W'(SCAN_DIV - 1));
  assign sub_last_c   = (sub_q == SUB_W'(PH_LEN - 1));
  assign slot_start_c = (tick_q == '0);
  assign frame_end_c  = en && tick_last_c && (slot_q == SLOT_H1);

  assign slot       = slot_q;
  assign phase      = phase_q;
  assign frame_done = frame_done_q;

  // Advance tick/phase within a slot, wrap slots, flag the last cycle of a frame.
  always_comb begin
    tick_d       = tick_q;
    sub_d        = sub_q;
    phase_d      = phase_q;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    if (!en) begin
      tick_d  = '0;
      sub_d   = '0;
      phase_d = '0;
      slot_d  = SLOT_S0;
    end else if (tick_last_c) begin
      tick_d       = '0;
      sub_d        = '0;
      phase_d      = '0;
      slot_d       = (slot_q == SLOT_H1) ? SLOT_S0 : slot_q + SLOT_W'(1);
      frame_done_d = (slot_q == SLOT_H1);
    end else begin
      tick_d = tick_q + TICK_W'(1);
      if (sub_last_c) begin
        sub_d   = '0;
        phase_d = phase_q + PHASE_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      sub_q        <= '0;
      phase_q      <= '0;
      slot_q       <= SLOT_S0;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Six-digit seven-segment scan controller with PWM brightness, blanking, LZ suppression and colon blink.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2:0]            bright,
  input  logic                  lz_en,
  input  logic                  colon_en,
  input  logic [SEG_W-1:0]      seg_s0,
  input  logic [SEG_W-1:0]      seg_s1,
  input  logic [SEG_W-1:0]      seg_m0,
  input  logic [SEG_W-1:0]      seg_m1,
  input  logic [SEG_W-1:0]      seg_h0,
  input  logic [SEG_W-1:0]      seg_h1,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0]  slot;
  logic [PHASE_W-1:0] phase;
  logic               slot_start_c;
  logic               frame_end_c;

  logic [SEG_W-1:0]   seg_in_c [NUM_DIGITS];
  logic [SEG_W-1:0]   pat_q    [NUM_DIGITS];
  logic [SEG_W-1:0]   pat_d    [NUM_DIGITS];
  logic [2:0]         bright_q, bright_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               blink_q, blink_d;
  disp_out_t          out_q, out_d;
  scan_state_t        state_c;
  logic               lz_hide_c;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .slot         (slot),
    .phase        (phase),
    .slot_start_c (slot_start_c),
    .frame_end_c  (frame_end_c),
    .frame_done   (frame_done)
  );

  assign seg_in_c[0] = seg_s0;
  assign seg_in_c[1] = seg_s1;
  assign seg_in_c[2] = seg_m0;
  assign seg_in_c[3] = seg_m1;
  assign seg_in_c[4] = seg_h0;
  assign seg_in_c[5] = seg_h1;

  assign state_c   = phase_state(phase, bright_q);
  assign lz_hide_c = lz_en && (slot == SLOT_H1) && (pat_q[5] == SEG_ZERO);

  assign seg = out_q.seg;
  assign dp  = out_q.dp;
  assign an  = out_q.an;

  // Brightness sample per slot, tear-free pattern latch per frame, colon blink divider.
  always_comb begin
    bright_d    = bright_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pat_d[i] = pat_q[i];
    end
    if (slot_start_c) begin
      bright_d = bright;
    end
    if (en && slot_start_c && (slot == SLOT_S0)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pat_d[i] = seg_in_c[i];
      end
    end
    if (frame_end_c) begin
      if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  // Next display pin values from the current slot and phase.
  always_comb begin
    out_d = DISP_OFF;
    if (en && (state_c == DRIVE) && !lz_hide_c) begin
      out_d.an  = ~(NUM_DIGITS'(1) << slot);
      out_d.seg = pat_q[slot];
      out_d.dp  = !(((slot == SLOT_M0) || (slot == SLOT_H0)) && colon_en && blink_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q    <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      out_q       <= DISP_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pat_q[i] <= SEG_BLANK;
      end
    end else begin
      bright_q    <= bright_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      out_q       <= out_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pat_q[i] <= pat_d[i];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned SCAN_DIV     = 16;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int          SLOT_LEN     = 16;
  localparam int          FRAME_LEN    = 6 * SLOT_LEN;
  localparam int          PH_LEN       = SLOT_LEN / 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] bright;
  logic       lz_en;
  logic       colon_en;
  logic [6:0] seg_in [6];
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  // reference model state
  int         m_n;
  int         m_frames;
  logic [2:0] m_bright;
  logic [6:0] m_pat [6];
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  int n_checks;
  int n_pass;

  seven_seg_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bright     (bright),
    .lz_en      (lz_en),
    .colon_en   (colon_en),
    .seg_s0     (seg_in[0]),
    .seg_s1     (seg_in[1]),
    .seg_m0     (seg_in[2]),
    .seg_m1     (seg_in[3]),
    .seg_h0     (seg_in[4]),
    .seg_h1     (seg_in[5]),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_frames = 0;
    m_bright = 3'd0;
    for (int i = 0; i < 6; i++) m_pat[i] = 7'h7F;
  endtask

  // One clock edge of the reference: position in the frame decides everything.
  task automatic model_step();
    int   pos;
    int   sl;
    int   tk;
    int   ph;
    logic drive;
    if (!en) begin
      e_an     = 6'h3F;
      e_seg    = 7'h7F;
      e_dp     = 1'b1;
      e_fd     = 1'b0;
      m_n      = 0;
      m_bright = bright;
    end else begin
      pos = m_n % FRAME_LEN;
      sl  = pos / SLOT_LEN;
      tk  = pos % SLOT_LEN;
      ph  = tk / PH_LEN;
      if (pos == 0) begin
        for (int i = 0; i < 6; i++) m_pat[i] = seg_in[i];
      end
      drive = (ph >= 1) && (ph <= int'(m_bright)) &&
              !(lz_en && (sl == 5) && (m_pat[5] == 7'b1000000));
      if (tk == 0) m_bright = bright;
      e_an  = drive ? ~(6'(1) << sl) : 6'h3F;
      e_seg = drive ? m_pat[sl] : 7'h7F;
      e_dp  = !(drive && ((sl == 2) || (sl == 4)) && colon_en &&
                (((m_frames / BLINK_FRAMES) % 2) == 1));
      e_fd  = (pos == FRAME_LEN - 1);
      if (e_fd) m_frames++;
      m_n++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("an_onecold", 32'($countones(~an) <= 1), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(an), 32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'(1));
    check({tag, "_fd"}, 32'(frame_done), 32'(0));
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    bright   = 3'd0;
    lz_en    = 1'b0;
    colon_en = 1'b0;
    for (int i = 0; i < 6; i++) seg_in[i] = 7'b1111001;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    en     = 1'b1;
    bright = 3'd7;

    // full brightness, all digits "1"
    repeat (2 * FRAME_LEN) cycle();

    // reduced brightness
    bright = 3'd3;
    repeat (FRAME_LEN) cycle();

    // colon plus leading-zero suppression, then a non-zero hour MSB
    colon_en  = 1'b1;
    lz_en     = 1'b1;
    seg_in[5] = 7'b1000000;
    repeat (2 * FRAME_LEN) cycle();
    seg_in[5] = 7'b0100100;
    repeat (2 * FRAME_LEN) cycle();

    // randomized inputs, including mid-frame pattern changes and en drops
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 4) seg_in[$urandom_range(0, 4)] = 7'($urandom);
      if ($urandom_range(0, 99) < 2)
        seg_in[5] = ($urandom_range(0, 1) == 0) ? 7'b1000000 : 7'($urandom);
      if ($urandom_range(0, 199) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 199) == 0) colon_en = ~colon_en;
      if (en && ($urandom_range(0, 399) == 0)) en = 1'b0;
      else if (!en && ($urandom_range(0, 9) == 0)) en = 1'b1;
      cycle();
    end

    // asynchronous reset in the middle of slot 3
    en     = 1'b1;
    bright = 3'd7;
    lz_en  = 1'b0;
    k      = 0;
    while ((k < 3 * FRAME_LEN) && ((m_n % FRAME_LEN) != 3 * SLOT_LEN + 8)) begin
      cycle();
      k++;
    end
    check("reach_slot3", 32'((m_n % FRAME_LEN) == 3 * SLOT_LEN + 8), 32'(1));
    check("slot3_driving", 32'(an), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    repeat (FRAME_LEN + 40) cycle();

    // drop en mid-frame, then resume from slot 0
    en = 1'b0;
    cycle();
    check("en_low_an", 32'(an), 32'h3F);
    repeat (5) cycle();
    en = 1'b1;
    repeat (2 * FRAME_LEN) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scan controller for the six-digit HH:MM:SS seven-segment display. It takes the six decoded segment patterns (active-low, `0` = segment lit) from the BCD-to-segment decoder and shares one segment bus across six digits. It drives the segment bus, the decimal point and six active-low anode enables, and adds brightness PWM, anti-ghost blanking, hour leading-zero suppression and a blinking colon. It sits between the decoder and the board pins.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot. Must be a multiple of 8 and ≥ 8.
- `BLINK_FRAMES`, 500: full six-digit frames per colon blink half-period. Must be ≥ 1.
- `clk`  in  1  system clock, single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  scan enable; low blanks the display
- `bright`  in  3  brightness, 0 = off, 7 = max
- `lz_en`  in  1  suppress the hour MSB digit when it shows "0"
- `colon_en`  in  1  enable the blinking colon dots
- `seg_s0`, `seg_s1`, `seg_m0`, `seg_m1`, `seg_h0`, `seg_h1`  in  7 each  decoded patterns: sec LSB/MSB, min LSB/MSB, hour LSB/MSB
- `seg`  out  7  shared segment bus, active-low
- `dp`  out  1  decimal point, active-low
- `an`  out  6  digit anodes, active-low; `an[0]` is the rightmost digit
- `frame_done`  out  1  one-cycle pulse per completed frame

## Operation
- Slot order and anode mapping:
  - slot 0 = `seg_s0` on `an[0]`
  - slot 1 = `seg_s1` on `an[1]`
  - slot 2 = `seg_m0` on `an[2]`
  - slot 3 = `seg_m1` on `an[3]`
  - slot 4 = `seg_h0` on `an[4]`
  - slot 5 = `seg_h1` on `an[5]`
  - After slot 5 the scan wraps to slot 0.
- `tick_cnt` counts 0..SCAN_DIV-1 within a slot. At the terminal count it clears and `slot` advances.
- Each slot is split into 8 phases: `p = tick_cnt / (SCAN_DIV/8)`. The phase selects the slot state:
  - BLANK when p == 0 (anti-ghost): all anodes off, `seg` = 7'h7F.
  - DRIVE when 1 ≤ p ≤ `bright_q`: only the slot's anode is low; `seg` = the latched pattern for that slot.
  - DARK when p > `bright_q`: same outputs as BLANK.
- `bright_q` is sampled from `bright` only when `tick_cnt` == 0. A change mid-slot takes effect at the next slot.
- Input pattern latch: all six patterns are captured together at frame start (`slot` == 0, `tick_cnt` == 0). This prevents tearing while the counters roll.
- Leading-zero suppression: when `lz_en` = 1 and the latched `seg_h1` == 7'b1000000, slot 5 stays in BLANK/DARK output for the whole slot. Slot timing is unchanged.
- Colon:
  - `blink` toggles after every BLINK_FRAMES completed frames.
  - `dp` = 0 only during DRIVE of slots 2 and 4, and only when `colon_en` && `blink`. Otherwise `dp` = 1.
- `en` low:
  - Synchronously clears `tick_cnt` and `slot`.
  - Holds the frame counter and `blink`.
  - Forces blank outputs.
  - When `en` rises, the scan restarts at slot 0, phase 0, with a fresh pattern latch.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect the counter and state values of cycle t.
- Reset values (asynchronous, immediate, including mid-frame):
  - `an` = 6'b111111, `seg` = 7'h7F, `dp` = 1, `frame_done` = 0
  - `tick_cnt` = 0, `slot` = 0, frame counter = 0, `blink` = 0, `bright_q` = 0, pattern latches = 7'h7F
- `frame_done` is high for exactly one cycle: the cycle after the last cycle of slot 5. It is not asserted while `en` = 0.
- Frame length is 6·SCAN_DIV cycles. The colon period is 2·BLINK_FRAMES frames.
- `bright` = 0 means the whole slot is BLANK/DARK: no anode is ever asserted.
- At most one `an` bit is low in any cycle. At slot boundaries every anode is high for at least SCAN_DIV/8 cycles.

## Structure
- Shared package `seven_seg_pkg` holds:
  - `SEG_BLANK` = 7'h7F and `SEG_ZERO` = 7'b1000000
  - slot index constants `SLOT_S0`..`SLOT_H1`
  - the `scan_state_t` enum {BLANK, DRIVE, DARK}
- One sub-module, `scan_tick_gen`, owns `tick_cnt`, the `slot` wrap, phase extraction and the `frame_done` strobe. The top level holds the pattern latches, brightness and blink logic, and the output registers.

## Test plan
All scenarios use SCAN_DIV = 16 and BLINK_FRAMES = 2.
- Reset, then `en` = 1, `bright` = 7, all patterns = 7'b1111001 ("1"):
  - Each slot shows 2 cycles of `an` = 6'h3F, then 14 cycles with a single anode low in order `an[0]`..`an[5]`.
  - `frame_done` pulses every 96 cycles.
- `bright` = 3: each slot has exactly 6 DRIVE cycles (phases 1–3). A change of `bright` to 0 mid-slot 2 has no effect until slot 3; from slot 3 on, `an` stays at 6'h3F.
- `lz_en` = 1 with `seg_h1` = 7'b1000000: `an[5]` is never low. With `seg_h1` = 7'b0100100, `an[5]` drives.
- `colon_en` = 1: `dp` = 0 only during DRIVE of slots 2 and 4, in frames 2–3, 6–7, and so on after reset. It is never 0 in frames 0–1.
- Change `seg_s0` mid-frame: `seg` in slot 0 of the same frame keeps the old value. The new value appears from the next frame.
- Assert `rst_n` = 0 mid-slot 3: outputs go to reset values with no clock edge. Drop `en` mid-frame: the cycle after the next edge, `an` = 6'h3F; when `en` rises, the scan resumes at slot 0.
